vc_flit_buffer: RTL

Parametrised per-virtual-channel flit storage register bank that generalises the single 32-bit enabled register into NUM_VC independent circular FIFOs of DEPTH entries each, DATA_W bits wide. It sits at each router input port: the link side writes flits tagged with a VC id, and the switch-allocation side reads a selected VC. It returns one credit per flit consumed, and flags overflow and underflow conditions.

---
 rtl/vc_flit_buffer_if.sv | 32 +++
 rtl/vc_flit_buffer.sv | 115 +++++++++++
 2 files changed

// File: rtl/vc_flit_buffer_if.sv
// Flit buffer bus: link-side write port, switch-side read port and status.
//   master: drives wr_en/wr_vc/din and rd_en/rd_vc, observes the rest
//   slave : the buffer itself
interface vc_flit_buffer_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned NUM_VC = 4
);
    localparam int unsigned VC_W = $clog2(NUM_VC);

    logic              wr_en;
    logic [VC_W-1:0]   wr_vc;
    logic [DATA_W-1:0] din;
    logic              rd_en;
    logic [VC_W-1:0]   rd_vc;
    logic [DATA_W-1:0] dout;
    logic              dout_valid;
    logic [NUM_VC-1:0] full;
    logic [NUM_VC-1:0] empty;
    logic [NUM_VC-1:0] credit_ret;
    logic              overflow_err;
    logic              underflow_err;

    modport master (
        output wr_en, wr_vc, din, rd_en, rd_vc,
        input  dout, dout_valid, full, empty, credit_ret, overflow_err, underflow_err
    );

    modport slave (
        input  wr_en, wr_vc, din, rd_en, rd_vc,
        output dout, dout_valid, full, empty, credit_ret, overflow_err, underflow_err
    );
endinterface

// File: rtl/vc_flit_buffer.sv
// Per-virtual-channel flit buffer: NUM_VC independent circular FIFOs of
// DEPTH entries, one registered read port, one credit pulse per flit read,
// sticky overflow/underflow flags.
// Ports:
//   clk  - rising-edge clock
//   clr  - asynchronous active-high reset
//   ce   - global enable; 0 freezes storage and pointer state
//   bus  - slave side of vc_flit_buffer_if (write/read requests, dout,
//          dout_valid, full/empty, credit_ret, error flags)
module vc_flit_buffer #(
    parameter int unsigned      DATA_W  = 32,
    parameter int unsigned      NUM_VC  = 4,
    parameter int unsigned      DEPTH   = 4,
    parameter logic [DATA_W-1:0] RST_VAL = DATA_W'(32'h6000_0000)
) (
    input  logic                clk,
    input  logic                clr,
    input  logic                ce,
    vc_flit_buffer_if.slave     bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] r_mem    [NUM_VC][DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr [NUM_VC];
    logic [PTR_W-1:0]  r_rd_ptr [NUM_VC];
    logic [CNT_W-1:0]  r_cnt    [NUM_VC];
    logic [NUM_VC-1:0] r_full;
    logic [NUM_VC-1:0] r_empty;
    logic [NUM_VC-1:0] r_credit;
    logic [DATA_W-1:0] r_dout;
    logic              r_dout_valid;
    logic              r_ovf;
    logic              r_udf;

    logic              w_wr_req;
    logic              w_rd_req;
    logic              w_wr_acc;
    logic              w_rd_acc;
    logic [NUM_VC-1:0] w_wr_hit;
    logic [NUM_VC-1:0] w_rd_hit;
    logic [CNT_W-1:0]  w_cnt_nxt [NUM_VC];

    // Explicit wrap so non-power-of-2 depths work.
    function automatic logic [PTR_W-1:0] f_ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Accept decisions use the pre-edge flags, so a full VC rejects a
    // concurrent write even when it is being read in the same cycle.
    assign w_wr_req = ce & bus.wr_en;
    assign w_rd_req = ce & bus.rd_en;
    assign w_wr_acc = w_wr_req & ~r_full[bus.wr_vc];
    assign w_rd_acc = w_rd_req & ~r_empty[bus.rd_vc];

    // Per-VC accepted operations and next occupancy.
    always_comb begin
        w_wr_hit = '0;
        w_rd_hit = '0;
        if (w_wr_acc) w_wr_hit[bus.wr_vc] = 1'b1;
        if (w_rd_acc) w_rd_hit[bus.rd_vc] = 1'b1;
        for (int v = 0; v < int'(NUM_VC); v++) begin
            w_cnt_nxt[v] = r_cnt[v];
            case ({w_wr_hit[v], w_rd_hit[v]})
                2'b10:   w_cnt_nxt[v] = r_cnt[v] + CNT_W'(1);
                2'b01:   w_cnt_nxt[v] = r_cnt[v] - CNT_W'(1);
                default: w_cnt_nxt[v] = r_cnt[v];
            endcase
        end
    end

    // Flit storage; intentionally not reset.
    always_ff @(posedge clk) begin
        if (w_wr_acc) r_mem[bus.wr_vc][r_wr_ptr[bus.wr_vc]] <= bus.din;
    end

    // Pointers, counts, flags, read data and error state.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            for (int v = 0; v < int'(NUM_VC); v++) begin
                r_wr_ptr[v] <= '0;
                r_rd_ptr[v] <= '0;
                r_cnt[v]    <= '0;
            end
            r_full       <= '0;
            r_empty      <= '1;
            r_credit     <= '0;
            r_dout       <= RST_VAL;
            r_dout_valid <= 1'b0;
            r_ovf        <= 1'b0;
            r_udf        <= 1'b0;
        end else begin
            r_dout_valid <= w_rd_acc;
            r_credit     <= w_rd_hit;
            if (w_rd_acc) r_dout <= r_mem[bus.rd_vc][r_rd_ptr[bus.rd_vc]];
            for (int v = 0; v < int'(NUM_VC); v++) begin
                r_cnt[v]   <= w_cnt_nxt[v];
                r_full[v]  <= (w_cnt_nxt[v] == CNT_W'(DEPTH));
                r_empty[v] <= (w_cnt_nxt[v] == CNT_W'(0));
                if (w_wr_hit[v]) r_wr_ptr[v] <= f_ptr_inc(r_wr_ptr[v]);
                if (w_rd_hit[v]) r_rd_ptr[v] <= f_ptr_inc(r_rd_ptr[v]);
            end
            if (w_wr_req && r_full[bus.wr_vc])  r_ovf <= 1'b1;
            if (w_rd_req && r_empty[bus.rd_vc]) r_udf <= 1'b1;
        end
    end

    assign bus.dout          = r_dout;
    assign bus.dout_valid    = r_dout_valid;
    assign bus.full          = r_full;
    assign bus.empty         = r_empty;
    assign bus.credit_ret    = r_credit;
    assign bus.overflow_err  = r_ovf;
    assign bus.underflow_err = r_udf;
endmodule
